// File: rtl/hart_issue_sched_if.sv
// Issue bundle between the hart state unit, the scheduler and IF.
// Master drives hart state and stall; slave returns the issue.
interface hart_issue_sched_if #(
    parameter int HART_ID_W = 2
);
    localparam int HART_NUM = 2 ** HART_ID_W;

    logic [HART_NUM-1:0]  acti_hstate;
    logic [HART_NUM-1:0]  prim_hstate;
    logic                 if_stall;
    logic                 issue_valid;
    logic [HART_ID_W-1:0] issue_hid;
    logic [HART_NUM-1:0]  issue_hstate;
    logic                 issue_switch;

    modport master (
        output acti_hstate,
        output prim_hstate,
        output if_stall,
        input  issue_valid,
        input  issue_hid,
        input  issue_hstate,
        input  issue_switch
    );

    modport slave (
        input  acti_hstate,
        input  prim_hstate,
        input  if_stall,
        output issue_valid,
        output issue_hid,
        output issue_hstate,
        output issue_switch
    );
endinterface

// File: rtl/hart_issue_sched.sv
// Fetch-side hart scheduler: weighted primary hart plus
// round-robin over the remaining active harts, registered outputs.
module hart_issue_sched #(
    parameter int HART_ID_W   = 2,
    parameter int PRIM_WEIGHT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hart_issue_sched_if.slave     bus
);
    localparam int HART_NUM = 2 ** HART_ID_W;
    localparam logic [2:0] PW = 3'(PRIM_WEIGHT);

    typedef enum logic [1:0] {
        IDLE,
        PRIM,
        ROBIN
    } st_e;

    st_e                  st_q, st_d;
    logic [HART_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [2:0]           prim_run_q, prim_run_d;
    logic                 have_last_q, have_last_d;
    logic                 issue_valid_q, issue_valid_d;
    logic [HART_ID_W-1:0] issue_hid_q, issue_hid_d;
    logic [HART_NUM-1:0]  issue_hstate_q, issue_hstate_d;
    logic                 issue_switch_q, issue_switch_d;

    logic [HART_NUM-1:0]  pa, oa;
    logic [HART_ID_W-1:0] prim_id;
    logic [HART_ID_W-1:0] rr_id;
    logic [HART_ID_W-1:0] cand;
    logic                 rr_hit;
    logic                 take_prim;
    logic                 any_acti;
    logic                 c_stall, c_idle, c_prim, c_robin;
    logic [HART_ID_W-1:0] new_id;

    // Candidate harts: encoded primary and circular search after rr_ptr
    always_comb begin
        pa      = bus.acti_hstate & bus.prim_hstate;
        oa      = bus.acti_hstate & ~bus.prim_hstate;
        prim_id = '0;
        for (int i = 0; i < HART_NUM; i++) begin
            if (pa[i]) prim_id = HART_ID_W'(i);
        end
        rr_hit = 1'b0;
        rr_id  = rr_ptr_q;
        cand   = '0;
        for (int k = 1; k <= HART_NUM; k++) begin
            cand = rr_ptr_q + HART_ID_W'(k);
            if (!rr_hit && oa[cand]) begin
                rr_hit = 1'b1;
                rr_id  = cand;
            end
        end
        any_acti  = |bus.acti_hstate;
        take_prim = (|pa) && ((prim_run_q < PW) || !(|oa));
        c_stall   = bus.if_stall;
        c_idle    = !bus.if_stall && !any_acti;
        c_prim    = !bus.if_stall && any_acti && take_prim;
        c_robin   = !bus.if_stall && any_acti && !take_prim;
    end

    // Next-state selection: stall hold, idle, primary slot or round-robin
    always_comb begin
        st_d           = st_q;
        rr_ptr_d       = rr_ptr_q;
        prim_run_d     = prim_run_q;
        have_last_d    = have_last_q;
        issue_valid_d  = issue_valid_q;
        issue_hid_d    = issue_hid_q;
        issue_hstate_d = issue_hstate_q;
        issue_switch_d = 1'b0;
        new_id         = c_prim ? prim_id : rr_id;
        unique case (1'b1)
            c_stall: begin
                if (!bus.acti_hstate[issue_hid_q]) begin
                    issue_valid_d  = 1'b0;
                    issue_hstate_d = '0;
                end
            end
            c_idle: begin
                st_d           = IDLE;
                issue_valid_d  = 1'b0;
                issue_hstate_d = '0;
                prim_run_d     = '0;
            end
            c_prim, c_robin: begin
                if (c_prim) begin
                    st_d       = PRIM;
                    prim_run_d = (prim_run_q < PW) ? prim_run_q + 3'd1 : PW;
                end else begin
                    st_d       = ROBIN;
                    rr_ptr_d   = rr_id;
                    prim_run_d = '0;
                end
                issue_switch_d         = !have_last_q || (new_id != issue_hid_q);
                have_last_d            = 1'b1;
                issue_valid_d          = 1'b1;
                issue_hid_d            = new_id;
                issue_hstate_d         = '0;
                issue_hstate_d[new_id] = 1'b1;
            end
            default: ;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q           <= IDLE;
            rr_ptr_q       <= HART_ID_W'(HART_NUM - 1);
            prim_run_q     <= '0;
            have_last_q    <= 1'b0;
            issue_valid_q  <= 1'b0;
            issue_hid_q    <= '0;
            issue_hstate_q <= '0;
            issue_switch_q <= 1'b0;
        end else begin
            st_q           <= st_d;
            rr_ptr_q       <= rr_ptr_d;
            prim_run_q     <= prim_run_d;
            have_last_q    <= have_last_d;
            issue_valid_q  <= issue_valid_d;
            issue_hid_q    <= issue_hid_d;
            issue_hstate_q <= issue_hstate_d;
            issue_switch_q <= issue_switch_d;
        end
    end

    assign bus.issue_valid  = issue_valid_q;
    assign bus.issue_hid    = issue_hid_q;
    assign bus.issue_hstate = issue_hstate_q;
    assign bus.issue_switch = issue_switch_q;
endmodule

// File: tb/tb_hart_issue_sched.sv
// Bench for hart_issue_sched: directed scenarios plus random
// traffic, checked against a slot-level reference model.
module tb_hart_issue_sched;
    localparam int W  = 2;
    localparam int N  = 4;
    localparam int PW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hart_issue_sched_if #(.HART_ID_W(W)) bus ();

    hart_issue_sched #(
        .HART_ID_W  (W),
        .PRIM_WEIGHT(PW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_valid, m_hid, m_sw, m_rr, m_prun, m_have;

    always @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0(bus.prim_hstate))
            else $error("illegal prim_hstate %b", bus.prim_hstate);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_valid = 0;
        m_hid   = 0;
        m_sw    = 0;
        m_rr    = N - 1;
        m_prun  = 0;
        m_have  = 0;
    endtask

    // one slot of the scheduling rules, in plain arithmetic
    task automatic m_step(input int a, input int p, input int s);
        int pa, oa, id;
        m_sw = 0;
        if (s != 0) begin
            if (((a >> m_hid) & 1) == 0) m_valid = 0;
            return;
        end
        if (a == 0) begin
            m_valid = 0;
            m_prun  = 0;
            return;
        end
        pa = a & p;
        oa = a & ~p & (N'(-1));
        id = 0;
        if (pa != 0 && (m_prun < PW || oa == 0)) begin
            for (int i = 0; i < N; i++) if (pa == (1 << i)) id = i;
            m_prun = (m_prun + 1 > PW) ? PW : m_prun + 1;
        end else begin
            for (int k = N; k >= 1; k--) begin
                if (((oa >> ((m_rr + k) % N)) & 1) != 0) id = (m_rr + k) % N;
            end
            m_rr   = id;
            m_prun = 0;
        end
        m_sw    = (m_have == 0 || id != m_hid) ? 1 : 0;
        m_hid   = id;
        m_valid = 1;
        m_have  = 1;
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".valid"}, 32'(bus.issue_valid), 32'(m_valid));
        chk({tag, ".hid"}, 32'(bus.issue_hid), 32'(m_hid));
        chk({tag, ".hstate"}, 32'(bus.issue_hstate),
            m_valid != 0 ? 32'(1 << m_hid) : 32'd0);
        chk({tag, ".switch"}, 32'(bus.issue_switch), 32'(m_sw));
    endtask

    task automatic step(input string tag, input int a, input int p, input int s);
        bus.acti_hstate = N'(a);
        bus.prim_hstate = N'(p);
        bus.if_stall    = s[0];
        @(posedge clk);
        m_step(a, p, s);
        #1;
        check_out(tag);
    endtask

    // async assert between edges, release before the next edge
    task automatic arst(input string tag);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check_out(tag);
        #3 rst_n = 1'b1;
    endtask

    int seq2 [16] = '{0,0,0,1,0,0,0,2,0,0,0,3,0,0,0,1};

    initial begin
        int a, p, s, r;
        bus.acti_hstate = '0;
        bus.prim_hstate = '0;
        bus.if_stall    = 1'b0;
        m_reset();
        #12;
        check_out("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) step("single", 'b0001, 'b0001, 0);
        chk("single.hid_const", 32'(bus.issue_hid), 32'd0);

        arst("arst0");
        for (int i = 0; i < 16; i++) begin
            step("weight", 'b1111, 'b0001, 0);
            chk("weight.seq", 32'(bus.issue_hid), 32'(seq2[i]));
        end

        for (int i = 0; i < 4; i++) step("robin", 'b1010, 0, 0);
        step("idle", 0, 0, 0);
        chk("idle.valid_const", 32'(bus.issue_valid), 32'd0);
        step("wake", 'b0100, 0, 0);
        chk("wake.hid_const", 32'(bus.issue_hid), 32'd2);

        step("stall", 'b0100, 0, 1);
        step("stall", 'b0100, 0, 1);
        step("stall_kill", 'b0000, 0, 1);
        chk("stall_kill.valid_const", 32'(bus.issue_valid), 32'd0);
        step("release", 'b0011, 'b0001, 0);
        chk("release.hid_const", 32'(bus.issue_hid), 32'd0);

        for (int i = 0; i < 4; i++) step("prim_run", 'b0110, 'b0100, 0);
        for (int i = 0; i < 5; i++) step("saturate", 'b0100, 'b0100, 0);
        step("prim_drop", 'b0010, 'b0100, 0);

        arst("arst1");
        step("post_rst", 'b1111, 0, 0);
        chk("post_rst.hid_const", 32'(bus.issue_hid), 32'd0);

        for (int i = 0; i < 800; i++) begin
            a = int'($urandom_range(0, 15));
            r = int'($urandom_range(0, 4));
            p = (r == 4) ? 0 : (1 << r);
            s = ($urandom_range(0, 3) == 0) ? 1 : 0;
            if ($urandom_range(0, 3) != 0 && a == 0) a = 'b1111;
            step("rand", a, p, s);
            if ($urandom_range(0, 99) == 0) arst("rand_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
